// File: rtl/cpu_pkg.sv
// Shared opcode map, hazard controller state type and source-register decode.
package cpu_pkg;

  localparam logic [3:0] OP_ADD    = 4'h0;
  localparam logic [3:0] OP_SUB    = 4'h1;
  localparam logic [3:0] OP_XOR    = 4'h2;
  localparam logic [3:0] OP_RED    = 4'h3;
  localparam logic [3:0] OP_SLL    = 4'h4;
  localparam logic [3:0] OP_SRA    = 4'h5;
  localparam logic [3:0] OP_ROR    = 4'h6;
  localparam logic [3:0] OP_PADDSB = 4'h7;
  localparam logic [3:0] OP_LW     = 4'h8;
  localparam logic [3:0] OP_SW     = 4'h9;
  localparam logic [3:0] OP_LLB    = 4'hA;
  localparam logic [3:0] OP_LHB    = 4'hB;
  localparam logic [3:0] OP_B      = 4'hC;
  localparam logic [3:0] OP_BR     = 4'hD;
  localparam logic [3:0] OP_PCS    = 4'hE;
  localparam logic [3:0] OP_HLT    = 4'hF;

  typedef enum logic [2:0] {
    ST_RUN        = 3'd0,
    ST_LOAD_STALL = 3'd1,
    ST_MEM_WAIT   = 3'd2,
    ST_DRAIN      = 3'd3,
    ST_HALTED     = 3'd4
  } hz_state_t;

  typedef struct packed {
    logic use_rs;
    logic use_rt;
    logic use_rd;
  } src_use_t;

  // LLB/LHB read rd because they merge a byte into the existing value.
  function automatic src_use_t src_regs(input logic [15:0] instr);
    src_use_t u;
    u = '0;
    case (instr[15:12])
      OP_ADD, OP_SUB, OP_XOR, OP_RED, OP_PADDSB: begin
        u.use_rs = 1'b1;
        u.use_rt = 1'b1;
      end
      OP_SLL, OP_SRA, OP_ROR, OP_LW, OP_BR: u.use_rs = 1'b1;
      OP_SW: begin
        u.use_rs = 1'b1;
        u.use_rd = 1'b1;
      end
      OP_LLB, OP_LHB: u.use_rd = 1'b1;
      OP_B, OP_PCS, OP_HLT: u = '0;
      default: u = '0;
    endcase
    return u;
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard: a load in D/E whose destination feeds the F/D instruction.
module load_use_detect
  import cpu_pkg::*;
(
  input  logic [15:0] instr_fd,
  input  logic        mem_read_de,
  input  logic        reg_write_de,
  input  logic [3:0]  rd_de,
  output logic        hz
);

  src_use_t use_f;
  logic     match;

  always_comb begin
    use_f = src_regs(instr_fd);
    match = (use_f.use_rs && (instr_fd[7:4]  == rd_de)) ||
            (use_f.use_rt && (instr_fd[3:0]  == rd_de)) ||
            (use_f.use_rd && (instr_fd[11:8] == rd_de));
    hz    = mem_read_de && reg_write_de && (rd_de != 4'd0) && match;
  end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline-register enable/flush controller: load-use stall, branch squash,
// memory-wait freeze and halt drain, plus a saturating stall-cycle counter.
module hazard_stall_ctrl
  import cpu_pkg::*;
#(
  parameter int DRAIN_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] instr_fd,
  input  logic        mem_read_de,
  input  logic        reg_write_de,
  input  logic [3:0]  rd_de,
  input  logic        branch_taken_d,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  output logic        pc_write,
  output logic        fd_enable,
  output logic        fd_flush,
  output logic        de_enable,
  output logic        de_flush,
  output logic        em_enable,
  output logic        mw_enable,
  output logic        halted,
  output logic [15:0] stall_count
);

  hz_state_t  state, state_nxt, ret_state, ret_nxt, eff;
  logic [1:0] cnt, cnt_nxt;
  logic       hz, mw;

  load_use_detect u_detect (
    .instr_fd     (instr_fd),
    .mem_read_de  (mem_read_de),
    .reg_write_de (reg_write_de),
    .rd_de        (rd_de),
    .hz           (hz)
  );

  assign mw = !imem_ready || !dmem_ready;

  always_comb begin
    pc_write  = 1'b1;
    fd_enable = 1'b1;
    fd_flush  = 1'b0;
    de_enable = 1'b1;
    de_flush  = 1'b0;
    em_enable = 1'b1;
    mw_enable = 1'b1;
    halted    = 1'b0;
    state_nxt = state;
    ret_nxt   = ret_state;
    cnt_nxt   = cnt;
    // After a memory wait clears, act as the state we were frozen in.
    eff       = (state == ST_MEM_WAIT) ? ret_state : state;
    if (rst) begin
      if (state == ST_HALTED) begin
        pc_write  = 1'b0;
        fd_enable = 1'b0;
        de_enable = 1'b0;
        em_enable = 1'b0;
        mw_enable = 1'b0;
        halted    = 1'b1;
      end else if (mw) begin
        pc_write  = 1'b0;
        fd_enable = 1'b0;
        de_enable = 1'b0;
        em_enable = 1'b0;
        mw_enable = 1'b0;
        state_nxt = ST_MEM_WAIT;
        if (state != ST_MEM_WAIT)
          ret_nxt = (state == ST_DRAIN) ? ST_DRAIN : ST_RUN;
      end else if (eff == ST_DRAIN) begin
        pc_write  = 1'b0;
        fd_enable = 1'b0;
        de_flush  = 1'b1;
        cnt_nxt   = cnt - 2'd1;
        state_nxt = (cnt <= 2'd1) ? ST_HALTED : ST_DRAIN;
      end else if (hz && (eff == ST_RUN)) begin
        pc_write  = 1'b0;
        fd_enable = 1'b0;
        de_flush  = 1'b1;
        state_nxt = ST_LOAD_STALL;
      end else if (instr_fd[15:12] == OP_HLT) begin
        pc_write  = 1'b0;
        fd_flush  = 1'b1;
        cnt_nxt   = 2'(DRAIN_CYCLES);
        state_nxt = ST_DRAIN;
      end else begin
        fd_flush  = branch_taken_d;
        state_nxt = ST_RUN;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_RUN;
      ret_state   <= ST_RUN;
      cnt         <= 2'd0;
      stall_count <= 16'd0;
    end else begin
      state     <= state_nxt;
      ret_state <= ret_nxt;
      cnt       <= cnt_nxt;
      if (!pc_write && (state != ST_HALTED) && (stall_count != 16'hFFFF))
        stall_count <= stall_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed scenarios plus randomized run against a behavioural pipeline-control model.
module tb_hazard_stall_ctrl;

  localparam int DC = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] instr_fd;
  logic        mem_read_de, reg_write_de, branch_taken_d, imem_ready, dmem_ready;
  logic [3:0]  rd_de;
  logic        pc_write, fd_enable, fd_flush, de_enable, de_flush, em_enable, mw_enable, halted;
  logic [15:0] stall_count;

  int n_checks = 0;
  int n_errors = 0;

  hazard_stall_ctrl #(.DRAIN_CYCLES(DC)) dut (
    .clk(clk), .rst(rst), .instr_fd(instr_fd), .mem_read_de(mem_read_de),
    .reg_write_de(reg_write_de), .rd_de(rd_de), .branch_taken_d(branch_taken_d),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready), .pc_write(pc_write),
    .fd_enable(fd_enable), .fd_flush(fd_flush), .de_enable(de_enable),
    .de_flush(de_flush), .em_enable(em_enable), .mw_enable(mw_enable),
    .halted(halted), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  // {pc_write, fd_enable, fd_flush, de_enable, de_flush, em_enable, mw_enable, halted}
  localparam logic [7:0] O_NORM   = 8'b1101_0110;
  localparam logic [7:0] O_BRANCH = 8'b1111_0110;
  localparam logic [7:0] O_BUBBLE = 8'b0001_1110;
  localparam logic [7:0] O_HLT    = 8'b0111_0110;
  localparam logic [7:0] O_FREEZE = 8'b0000_0000;
  localparam logic [7:0] O_HALTED = 8'b0000_0001;

  function automatic logic [7:0] outs();
    return {pc_write, fd_enable, fd_flush, de_enable, de_flush, em_enable, mw_enable, halted};
  endfunction

  // True when the instruction reads register r as a source operand.
  function automatic bit reads_reg(input logic [15:0] ins, input logic [3:0] r);
    case (ins[15:12])
      4'h0, 4'h1, 4'h2, 4'h3, 4'h7: return (ins[7:4] == r) || (ins[3:0] == r);
      4'h4, 4'h5, 4'h6, 4'h8, 4'hD: return ins[7:4] == r;
      4'h9:                         return (ins[7:4] == r) || (ins[11:8] == r);
      4'hA, 4'hB:                   return ins[11:8] == r;
      default:                      return 1'b0;
    endcase
  endfunction

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    instr_fd = 16'h0000; mem_read_de = 0; reg_write_de = 0; rd_de = 0;
    branch_taken_d = 0; imem_ready = 1; dmem_ready = 1;
  endtask

  task automatic do_reset();
    idle_inputs();
    nxt();
    rst = 1'b0;
    #2;
    rst = 1'b1;
    nxt();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle_inputs();
    imem_ready = 0;
    #3;
    n_checks++;
    if (outs() !== O_NORM) begin
      n_errors++; $display("FAIL reset_outputs got=%b exp=%b", outs(), O_NORM);
    end
    n_checks++;
    if (stall_count !== 16'd0) begin
      n_errors++; $display("FAIL reset_count got=%0d exp=0", stall_count);
    end
    imem_ready = 1;
    nxt();
    rst = 1'b1;
    nxt();
  endtask

  task automatic test_load_use();
    do_reset();
    mem_read_de = 1; reg_write_de = 1; rd_de = 4'd3; instr_fd = 16'h0132;
    #2;
    n_checks++;
    if (outs() !== O_BUBBLE) begin
      n_errors++; $display("FAIL load_use_stall got=%b exp=%b", outs(), O_BUBBLE);
    end
    nxt();
    #2;
    n_checks++;
    if (outs() !== O_NORM) begin
      n_errors++; $display("FAIL load_use_single got=%b exp=%b", outs(), O_NORM);
    end
    nxt();
    n_checks++;
    if (stall_count !== 16'd1) begin
      n_errors++; $display("FAIL load_use_count got=%0d exp=1", stall_count);
    end
  endtask

  task automatic test_no_stall();
    logic [15:0] ins [6];
    logic [3:0]  rdv [6];
    bit          stl [6];
    ins = '{16'h0100, 16'h1145, 16'h4143, 16'h9345, 16'hC333, 16'hA312};
    rdv = '{4'd0,     4'd3,     4'd3,     4'd3,     4'd3,     4'd3};
    stl = '{1'b0,     1'b0,     1'b0,     1'b1,     1'b0,     1'b1};
    for (int i = 0; i < 6; i++) begin
      do_reset();
      mem_read_de = 1; reg_write_de = 1; rd_de = rdv[i]; instr_fd = ins[i];
      #2;
      n_checks++;
      if (pc_write !== !stl[i]) begin
        n_errors++;
        $display("FAIL src_decode[%0d] instr=%h pc_write got=%b exp=%b", i, ins[i], pc_write, !stl[i]);
      end
    end
  endtask

  task automatic test_branch();
    do_reset();
    branch_taken_d = 1;
    #2;
    n_checks++;
    if (outs() !== O_BRANCH) begin
      n_errors++; $display("FAIL branch_squash got=%b exp=%b", outs(), O_BRANCH);
    end
    nxt();
    branch_taken_d = 0;
    #2;
    n_checks++;
    if (outs() !== O_NORM) begin
      n_errors++; $display("FAIL branch_one_cycle got=%b exp=%b", outs(), O_NORM);
    end
  endtask

  task automatic test_branch_hz();
    do_reset();
    mem_read_de = 1; reg_write_de = 1; rd_de = 4'd3; instr_fd = 16'h0132; branch_taken_d = 1;
    #2;
    n_checks++;
    if (outs() !== O_BUBBLE) begin
      n_errors++; $display("FAIL branch_hz_stall got=%b exp=%b", outs(), O_BUBBLE);
    end
    nxt();
    mem_read_de = 0;
    #2;
    n_checks++;
    if (outs() !== O_BRANCH) begin
      n_errors++; $display("FAIL branch_after_stall got=%b exp=%b", outs(), O_BRANCH);
    end
    nxt();
    branch_taken_d = 0;
  endtask

  task automatic test_drain_memwait();
    do_reset();
    instr_fd = 16'hF000;
    #2;
    n_checks++;
    if (outs() !== O_HLT) begin
      n_errors++; $display("FAIL hlt_decode got=%b exp=%b", outs(), O_HLT);
    end
    nxt();
    instr_fd = 16'h0000;
    #2;
    n_checks++;
    if (outs() !== O_BUBBLE) begin
      n_errors++; $display("FAIL drain_outputs got=%b exp=%b", outs(), O_BUBBLE);
    end
    nxt();
    dmem_ready = 0;
    for (int i = 0; i < 4; i++) begin
      #2;
      n_checks++;
      if (outs() !== O_FREEZE) begin
        n_errors++; $display("FAIL drain_freeze[%0d] got=%b exp=%b", i, outs(), O_FREEZE);
      end
      nxt();
    end
    dmem_ready = 1;
    for (int i = 0; i < 2; i++) begin
      #2;
      n_checks++;
      if (outs() !== O_BUBBLE) begin
        n_errors++; $display("FAIL drain_resume[%0d] got=%b exp=%b", i, outs(), O_BUBBLE);
      end
      nxt();
    end
    n_checks++;
    if (halted !== 1'b1 || stall_count !== 16'd8) begin
      n_errors++; $display("FAIL drain_halt halted=%b count=%0d exp halted=1 count=8", halted, stall_count);
    end
  endtask

  task automatic test_halt_reset();
    int cyc;
    do_reset();
    instr_fd = 16'hF000;
    cyc = 0;
    while (!halted && cyc < 20) begin
      nxt();
      instr_fd = 16'h0000;
      cyc++;
    end
    n_checks++;
    if (cyc != DC + 1) begin
      n_errors++; $display("FAIL halt_latency got=%0d exp=%0d", cyc, DC + 1);
    end
    for (int i = 0; i < 6; i++) begin
      imem_ready = 1'(i & 1);
      #2;
      n_checks++;
      if (outs() !== O_HALTED) begin
        n_errors++; $display("FAIL halted_sticky[%0d] got=%b exp=%b", i, outs(), O_HALTED);
      end
      nxt();
    end
    n_checks++;
    if (stall_count !== 16'(DC + 1)) begin
      n_errors++; $display("FAIL halted_count got=%0d exp=%0d", stall_count, DC + 1);
    end
    imem_ready = 0;
    #2;
    rst = 1'b0;
    #1;
    n_checks++;
    if (outs() !== O_NORM || stall_count !== 16'd0) begin
      n_errors++; $display("FAIL async_reset got=%b count=%0d exp=%b count=0", outs(), stall_count, O_NORM);
    end
    imem_ready = 1;
    nxt();
    rst = 1'b1;
    nxt();
  endtask

  task automatic test_saturation();
    do_reset();
    imem_ready = 0;
    repeat (65534) nxt();
    n_checks++;
    if (stall_count !== 16'hFFFE) begin
      n_errors++; $display("FAIL sat_near got=%h exp=fffe", stall_count);
    end
    repeat (6) nxt();
    n_checks++;
    if (stall_count !== 16'hFFFF) begin
      n_errors++; $display("FAIL sat_hold got=%h exp=ffff", stall_count);
    end
    imem_ready = 1;
  endtask

  task automatic test_random();
    bit         m_halted, m_bubble, pre_halted, hz, mw;
    int         m_drain, m_count, halt_age;
    logic [7:0] expv;
    logic [3:0] op;
    do_reset();
    m_halted = 0; m_bubble = 0; m_drain = 0; m_count = 0; halt_age = 0;
    for (int c = 0; c < 3000; c++) begin
      op = 4'($urandom_range(0, 15));
      if (op == 4'hF && $urandom_range(0, 7) != 0) op = 4'h0;
      instr_fd       = {op, 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))};
      mem_read_de    = 1'($urandom_range(0, 1));
      reg_write_de   = ($urandom_range(0, 3) != 0);
      rd_de          = 4'($urandom_range(0, 3));
      branch_taken_d = ($urandom_range(0, 3) == 0);
      imem_ready     = ($urandom_range(0, 7) != 0);
      dmem_ready     = ($urandom_range(0, 7) != 0);
      #2;
      hz = mem_read_de && reg_write_de && rd_de != 0 && reads_reg(instr_fd, rd_de);
      mw = !imem_ready || !dmem_ready;
      pre_halted = m_halted;
      if (m_halted) expv = O_HALTED;
      else if (mw) begin
        expv = O_FREEZE;
        m_bubble = 0;
      end else if (m_drain > 0) begin
        expv = O_BUBBLE;
        m_drain--;
        if (m_drain == 0) m_halted = 1;
      end else if (hz && !m_bubble) begin
        expv = O_BUBBLE;
        m_bubble = 1;
      end else begin
        m_bubble = 0;
        if (instr_fd[15:12] == 4'hF) begin
          expv = O_HLT;
          m_drain = DC;
        end else expv = branch_taken_d ? O_BRANCH : O_NORM;
      end
      if (!expv[7] && !pre_halted && m_count < 65535) m_count++;
      n_checks++;
      if (outs() !== expv) begin
        n_errors++; $display("FAIL rand_outputs cyc=%0d got=%b exp=%b", c, outs(), expv);
      end
      nxt();
      n_checks++;
      if (stall_count !== 16'(m_count)) begin
        n_errors++; $display("FAIL rand_count cyc=%0d got=%0d exp=%0d", c, stall_count, m_count);
      end
      if (m_halted) halt_age++;
      if (halt_age > 3) begin
        do_reset();
        m_halted = 0; m_bubble = 0; m_drain = 0; m_count = 0; halt_age = 0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_no_stall();
    test_branch();
    test_branch_hz();
    test_drain_memwait();
    test_halt_reset();
    test_saturation();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
